// File: rtl/keypad_time_entry.sv
// keypad_time_entry: collects keypad digits into a microwave-style MM:SS buffer
// and hands the buffer to the countdown timer with a one-cycle LOAD pulse on START.
// Optional feature macro: ENTRY_DEBOUNCE_EN adds a DEBOUNCE state that requires
// DEBOUNCE_CYCLES consecutive registered AI cycles before a press is accepted.
module keypad_time_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  BCD,
    input  logic        AI,
    input  logic        ENTRY_EN,
    input  logic        START,
    input  logic        CLR,
    output logic [3:0]  MIN_TENS,
    output logic [3:0]  MIN_ONES,
    output logic [3:0]  SEC_TENS,
    output logic [3:0]  SEC_ONES,
    output logic [2:0]  DIGIT_CNT,
    output logic        LOAD,
    output logic [15:0] TIME_OUT
);

`ifdef ENTRY_DEBOUNCE_EN
    typedef enum logic [1:0] {
        StIdle        = 2'd0,
        StDebounce    = 2'd1,
        StWaitRelease = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        StIdle        = 2'd0,
        StWaitRelease = 2'd2
    } state_e;
`endif

    localparam logic [4:0] DebLimit = 5'(DEBOUNCE_CYCLES);

    state_e      state_q, state_d;
    logic        ai_q;
    logic [3:0]  bcd_q;
    logic        start_q;
    logic        start_prev_q;
    logic [3:0]  min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
    logic [2:0]  cnt_q;
    logic        load_q;
    logic [15:0] time_out_q;
    logic        accept;
    logic        start_rise;

`ifdef ENTRY_DEBOUNCE_EN
    logic [3:0]  deb_cnt_q, deb_cnt_d;
`else
    logic        unused_deb_limit;
    assign unused_deb_limit = ^DebLimit;
`endif

    assign start_rise = start_q & ~start_prev_q;

    // Press detection: next FSM state and the single-cycle accept strobe.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
`ifdef ENTRY_DEBOUNCE_EN
        deb_cnt_d = deb_cnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (ai_q) begin
                    if (ENTRY_EN) begin
`ifdef ENTRY_DEBOUNCE_EN
                        // This cycle already counts as the first high sample.
                        if (DebLimit <= 5'd1) begin
                            accept  = 1'b1;
                            state_d = StWaitRelease;
                        end else begin
                            deb_cnt_d = 4'd1;
                            state_d   = StDebounce;
                        end
`else
                        accept  = 1'b1;
                        state_d = StWaitRelease;
`endif
                    end else begin
                        state_d = StWaitRelease;
                    end
                end
            end
`ifdef ENTRY_DEBOUNCE_EN
            StDebounce: begin
                if (!ai_q || !ENTRY_EN) begin
                    state_d = StIdle;
                end else if (({1'b0, deb_cnt_q} + 5'd1) >= DebLimit) begin
                    accept  = 1'b1;
                    state_d = StWaitRelease;
                end else begin
                    deb_cnt_d = deb_cnt_q + 4'd1;
                end
            end
`endif
            StWaitRelease: begin
                if (!ai_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Input registers, FSM state, entry buffer and load handshake.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            ai_q         <= 1'b0;
            bcd_q        <= 4'd0;
            start_q      <= 1'b0;
            start_prev_q <= 1'b0;
            min_tens_q   <= 4'd0;
            min_ones_q   <= 4'd0;
            sec_tens_q   <= 4'd0;
            sec_ones_q   <= 4'd0;
            cnt_q        <= 3'd0;
            load_q       <= 1'b0;
            time_out_q   <= 16'd0;
`ifdef ENTRY_DEBOUNCE_EN
            deb_cnt_q    <= 4'd0;
`endif
        end else begin
            state_q      <= state_d;
            ai_q         <= AI;
            bcd_q        <= BCD;
            start_q      <= START;
            start_prev_q <= start_q;
            load_q       <= 1'b0;
`ifdef ENTRY_DEBOUNCE_EN
            deb_cnt_q    <= deb_cnt_d;
`endif
            // CLR beats START beats a key; a key lost here is not retried.
            if (CLR) begin
                min_tens_q <= 4'd0;
                min_ones_q <= 4'd0;
                sec_tens_q <= 4'd0;
                sec_ones_q <= 4'd0;
                cnt_q      <= 3'd0;
            end else if (start_rise) begin
                if (cnt_q != 3'd0) begin
                    time_out_q <= {min_tens_q, min_ones_q, sec_tens_q, sec_ones_q};
                    load_q     <= 1'b1;
                    min_tens_q <= 4'd0;
                    min_ones_q <= 4'd0;
                    sec_tens_q <= 4'd0;
                    sec_ones_q <= 4'd0;
                    cnt_q      <= 3'd0;
                end
            end else if (accept && (bcd_q <= 4'd9) && (cnt_q < 3'd4)) begin
                min_tens_q <= min_ones_q;
                min_ones_q <= sec_tens_q;
                sec_tens_q <= sec_ones_q;
                sec_ones_q <= bcd_q;
                cnt_q      <= cnt_q + 3'd1;
            end
        end
    end

    assign MIN_TENS  = min_tens_q;
    assign MIN_ONES  = min_ones_q;
    assign SEC_TENS  = sec_tens_q;
    assign SEC_ONES  = sec_ones_q;
    assign DIGIT_CNT = cnt_q;
    assign LOAD      = load_q;
    assign TIME_OUT  = time_out_q;

endmodule

// File: tb/tb_keypad_time_entry.sv
// tb_keypad_time_entry: directed bench for keypad_time_entry (default or ENTRY_DEBOUNCE_EN).
module tb_keypad_time_entry;

    logic        CLK = 1'b0;
    logic        RST, AI, ENTRY_EN, START, CLR;
    logic [3:0]  BCD;
    logic [3:0]  MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES;
    logic [2:0]  DIGIT_CNT;
    logic        LOAD;
    logic [15:0] TIME_OUT;
    logic [15:0] buf_w;

    int vectors = 0;
    int miscompares = 0;

`ifdef ENTRY_DEBOUNCE_EN
    localparam int Lat = 5;
`else
    localparam int Lat = 2;
`endif

    always #5 CLK = ~CLK;

    assign buf_w = {MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES};

    keypad_time_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .CLK(CLK), .RST(RST), .BCD(BCD), .AI(AI), .ENTRY_EN(ENTRY_EN),
        .START(START), .CLR(CLR), .MIN_TENS(MIN_TENS), .MIN_ONES(MIN_ONES),
        .SEC_TENS(SEC_TENS), .SEC_ONES(SEC_ONES), .DIGIT_CNT(DIGIT_CNT),
        .LOAD(LOAD), .TIME_OUT(TIME_OUT)
    );

    // Called at a negedge; holds the key for 'hold' cycles then releases for 3.
    task automatic press(input logic [3:0] d, input int hold);
        BCD = d;
        AI  = 1'b1;
        repeat (hold) @(negedge CLK);
        AI = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_reset;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        vectors++;
        if (buf_w !== 16'h0000) begin
            $display("FAIL reset_buf actual=%h expected=0000", buf_w); miscompares++;
        end
        vectors++;
        if (DIGIT_CNT !== 3'd0) begin
            $display("FAIL reset_cnt actual=%0d expected=0", DIGIT_CNT); miscompares++;
        end
        vectors++;
        if (LOAD !== 1'b0 || TIME_OUT !== 16'h0000) begin
            $display("FAIL reset_load actual=%b/%h expected=0/0000", LOAD, TIME_OUT);
            miscompares++;
        end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_latency;
        BCD = 4'd1;
        AI  = 1'b1;
        repeat (Lat - 1) @(negedge CLK);
        vectors++;
        if (DIGIT_CNT !== 3'd0) begin
            $display("FAIL latency_early actual=%0d expected=0", DIGIT_CNT); miscompares++;
        end
        @(negedge CLK);
        vectors++;
        if (DIGIT_CNT !== 3'd1 || buf_w !== 16'h0001) begin
            $display("FAIL latency_edge actual=%0d/%h expected=1/0001", DIGIT_CNT, buf_w);
            miscompares++;
        end
        repeat (4) @(negedge CLK);
        AI = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_entry;
        press(4'd3, 6);
        press(4'd0, 6);
        vectors++;
        if (buf_w !== 16'h0130 || DIGIT_CNT !== 3'd3) begin
            $display("FAIL entry_130 actual=%h/%0d expected=0130/3", buf_w, DIGIT_CNT);
            miscompares++;
        end
    endtask

    task automatic test_start;
        int          loads;
        logic [15:0] tout;
        loads = 0;
        tout  = 16'hxxxx;
        START = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (i == 0) START = 1'b0;
            if (LOAD === 1'b1) begin
                loads++;
                tout = TIME_OUT;
            end
        end
        vectors++;
        if (loads != 1) begin
            $display("FAIL start_pulse_len actual=%0d expected=1", loads); miscompares++;
        end
        vectors++;
        if (tout !== 16'h0130) begin
            $display("FAIL start_time_out actual=%h expected=0130", tout); miscompares++;
        end
        vectors++;
        if (buf_w !== 16'h0000 || DIGIT_CNT !== 3'd0) begin
            $display("FAIL start_clear actual=%h/%0d expected=0000/0", buf_w, DIGIT_CNT);
            miscompares++;
        end
    endtask

    task automatic test_start_empty;
        int loads;
        loads = 0;
        START = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (i == 0) START = 1'b0;
            if (LOAD !== 1'b0) loads++;
        end
        vectors++;
        if (loads != 0 || TIME_OUT !== 16'h0130) begin
            $display("FAIL start_empty actual=%0d/%h expected=0/0130", loads, TIME_OUT);
            miscompares++;
        end
    endtask

    task automatic test_full;
        for (int i = 0; i < 4; i++) press(4'd9, 6);
        vectors++;
        if (buf_w !== 16'h9999 || DIGIT_CNT !== 3'd4) begin
            $display("FAIL full_9999 actual=%h/%0d expected=9999/4", buf_w, DIGIT_CNT);
            miscompares++;
        end
        press(4'd5, 6);
        vectors++;
        if (buf_w !== 16'h9999 || DIGIT_CNT !== 3'd4) begin
            $display("FAIL full_ignore actual=%h/%0d expected=9999/4", buf_w, DIGIT_CNT);
            miscompares++;
        end
    endtask

    task automatic test_clr;
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        vectors++;
        if (buf_w !== 16'h0000 || DIGIT_CNT !== 3'd0 || TIME_OUT !== 16'h0130) begin
            $display("FAIL clr actual=%h/%0d/%h expected=0000/0/0130", buf_w, DIGIT_CNT,
                     TIME_OUT);
            miscompares++;
        end
    endtask

    task automatic test_hold;
        press(4'd7, 20);
        vectors++;
        if (buf_w !== 16'h0007 || DIGIT_CNT !== 3'd1) begin
            $display("FAIL hold_once actual=%h/%0d expected=0007/1", buf_w, DIGIT_CNT);
            miscompares++;
        end
    endtask

    task automatic test_invalid;
        press(4'd12, 6);
        vectors++;
        if (buf_w !== 16'h0007 || DIGIT_CNT !== 3'd1) begin
            $display("FAIL invalid_digit actual=%h/%0d expected=0007/1", buf_w, DIGIT_CNT);
            miscompares++;
        end
    endtask

    task automatic test_entry_en;
        ENTRY_EN = 1'b0;
        BCD = 4'd5;
        AI  = 1'b1;
        repeat (4) @(negedge CLK);
        ENTRY_EN = 1'b1;
        repeat (8) @(negedge CLK);
        vectors++;
        if (buf_w !== 16'h0007 || DIGIT_CNT !== 3'd1) begin
            $display("FAIL entry_dis_held actual=%h/%0d expected=0007/1", buf_w, DIGIT_CNT);
            miscompares++;
        end
        AI = 1'b0;
        repeat (3) @(negedge CLK);
        press(4'd5, 6);
        vectors++;
        if (buf_w !== 16'h0075 || DIGIT_CNT !== 3'd2) begin
            $display("FAIL entry_repress actual=%h/%0d expected=0075/2", buf_w, DIGIT_CNT);
            miscompares++;
        end
    endtask

    task automatic test_clr_same_edge;
        BCD = 4'd8;
        AI  = 1'b1;
        repeat (Lat - 1) @(negedge CLK);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        vectors++;
        if (buf_w !== 16'h0000 || DIGIT_CNT !== 3'd0) begin
            $display("FAIL clr_accept actual=%h/%0d expected=0000/0", buf_w, DIGIT_CNT);
            miscompares++;
        end
        repeat (6) @(negedge CLK);
        AI = 1'b0;
        repeat (3) @(negedge CLK);
        vectors++;
        if (buf_w !== 16'h0000 || DIGIT_CNT !== 3'd0) begin
            $display("FAIL clr_key_lost actual=%h/%0d expected=0000/0", buf_w, DIGIT_CNT);
            miscompares++;
        end
    endtask

    task automatic test_reset_held;
        press(4'd2, 6);
        BCD = 4'd4;
        AI  = 1'b1;
        repeat (Lat + 1) @(negedge CLK);
        vectors++;
        if (buf_w !== 16'h0024 || DIGIT_CNT !== 3'd2) begin
            $display("FAIL pre_reset actual=%h/%0d expected=0024/2", buf_w, DIGIT_CNT);
            miscompares++;
        end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        repeat (Lat + 2) @(negedge CLK);
        vectors++;
        if (buf_w !== 16'h0004 || DIGIT_CNT !== 3'd1) begin
            $display("FAIL reset_held_key actual=%h/%0d expected=0004/1", buf_w, DIGIT_CNT);
            miscompares++;
        end
        AI = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

`ifdef ENTRY_DEBOUNCE_EN
    task automatic test_glitch;
        BCD = 4'd6;
        AI  = 1'b1;
        repeat (2) @(negedge CLK);
        AI = 1'b0;
        repeat (6) @(negedge CLK);
        vectors++;
        if (buf_w !== 16'h0004 || DIGIT_CNT !== 3'd1) begin
            $display("FAIL glitch actual=%h/%0d expected=0004/1", buf_w, DIGIT_CNT);
            miscompares++;
        end
    endtask
`endif

    initial begin
        RST = 1'b1; AI = 1'b0; BCD = 4'd0; ENTRY_EN = 1'b1; START = 1'b0; CLR = 1'b0;
        @(negedge CLK);
        test_reset();
        test_latency();
        test_entry();
        test_start();
        test_start_empty();
        test_full();
        test_clr();
        test_hold();
        test_invalid();
        test_entry_en();
        test_clr_same_edge();
        test_reset_held();
`ifdef ENTRY_DEBOUNCE_EN
        test_glitch();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
